// File: rtl/mbp_choice_sync.sv
// Tournament choice predictor: per-slot saturating chooser, sync-read RAMs,
// RMW update with forwarding, init sweep; MBP_CHOICE_GHR_HASH_EN hashes rows.
package config_pkg;
  typedef struct packed {
    int unsigned VLEN;
    int unsigned INSTR_PER_FETCH;
    bit          RVC;
    int unsigned ChoiceCtrBits;
  } cva6_cfg_t;

  localparam cva6_cfg_t cva6_cfg_empty = '{
    VLEN:            32,
    INSTR_PER_FETCH: 2,
    RVC:             1'b1,
    ChoiceCtrBits:   2
  };
endpackage

module mbp_choice_sync
  import config_pkg::*;
#(
  parameter cva6_cfg_t   CVA6Cfg    = cva6_cfg_empty,
  parameter int unsigned NR_ENTRIES = 1024,
  parameter int unsigned CTR_BITS   = CVA6Cfg.ChoiceCtrBits,
  parameter int unsigned GHR_BITS   = 8
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               flush_bp_i,
  input  logic                               debug_mode_i,
  input  logic [CVA6Cfg.VLEN-1:0]            vpc_i,
  input  logic [GHR_BITS-1:0]                ghr_i,
  input  logic                               update_valid_i,
  input  logic [CVA6Cfg.VLEN-1:0]            update_pc_i,
  input  logic [GHR_BITS-1:0]                update_ghr_i,
  input  logic                               update_taken_i,
  input  logic                               lbp_valid_i,
  input  logic                               lbp_taken_i,
  input  logic                               gbp_valid_i,
  input  logic                               gbp_taken_i,
  output logic [CVA6Cfg.INSTR_PER_FETCH-1:0] select_prediction_o,
  output logic                               ready_o
);

  localparam int unsigned IPF = CVA6Cfg.INSTR_PER_FETCH;
  localparam int unsigned NR_ROWS = NR_ENTRIES / IPF;
  localparam int unsigned ROW_BITS = $clog2(NR_ROWS);
  localparam int unsigned OFFSET = CVA6Cfg.RVC ? 1 : 2;
  localparam int unsigned ROW_ADDR_BITS = $clog2(IPF);
  localparam int unsigned BANK_W =
    (ROW_ADDR_BITS > 0) ? ROW_ADDR_BITS : 1;
  localparam int unsigned RLO = ROW_ADDR_BITS + OFFSET;

  localparam logic [CTR_BITS-1:0] INIT_VAL =
    CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
  localparam logic [CTR_BITS-1:0] CTR_MAX = '1;
  localparam logic [ROW_BITS-1:0] LAST_ROW =
    ROW_BITS'(NR_ROWS - 1);

  typedef enum logic {
    INIT,
    RUN
  } state_e;

  typedef struct packed {
    logic                valid;
    logic [ROW_BITS-1:0] row;
    logic [BANK_W-1:0]   bank;
    logic                inc;
    logic                dec;
  } upd_t;

  state_e              state_q, state_d;
  logic [ROW_BITS-1:0] init_row_q, init_row_d;

  logic [ROW_BITS-1:0] pred_row;
  logic [ROW_BITS-1:0] upd_row;
  logic [BANK_W-1:0]   upd_bank;

  logic                g_ok, l_ok;
  logic                upd_acc;
  logic                run_rd;
  logic                init_we;
  logic                s1_we;
  logic                s1_hit;
  upd_t                s1_d, s1_q;
  logic                fwd_q;
  logic [CTR_BITS-1:0] fwd_val_q;
  logic [CTR_BITS-1:0] s1_rd, s1_cur, s1_new;

  logic [CTR_BITS-1:0] upd_rd [IPF];
  logic [IPF-1:0]      pred_msb;

  logic                unused_bits;

  assign unused_bits =
    ^{vpc_i, update_pc_i, ghr_i, update_ghr_i};

`ifdef MBP_CHOICE_GHR_HASH_EN
  assign pred_row =
    vpc_i[RLO+:ROW_BITS] ^ ROW_BITS'(ghr_i);
  assign upd_row =
    update_pc_i[RLO+:ROW_BITS] ^ ROW_BITS'(update_ghr_i);
`else
  assign pred_row = vpc_i[RLO+:ROW_BITS];
  assign upd_row  = update_pc_i[RLO+:ROW_BITS];
`endif

  if (CVA6Cfg.RVC && ROW_ADDR_BITS > 0) begin : g_bank_pc
    assign upd_bank = update_pc_i[OFFSET+:BANK_W];
  end else begin : g_bank_zero
    assign upd_bank = '0;
  end

  always_comb begin
    state_d    = state_q;
    init_row_d = init_row_q;
    unique case (state_q)
      INIT: begin
        if (flush_bp_i) begin
          init_row_d = '0;
        end else begin
          init_row_d = init_row_q + ROW_BITS'(1);
          if (init_row_q == LAST_ROW) state_d = RUN;
        end
      end
      RUN: begin
        if (flush_bp_i) begin
          state_d    = INIT;
          init_row_d = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= INIT;
      init_row_q <= '0;
    end else begin
      state_q    <= state_d;
      init_row_q <= init_row_d;
    end
  end

  assign ready_o = (state_q == RUN);
  assign run_rd  = (state_q == RUN) & ~flush_bp_i;
  assign init_we = rst_ni & (state_q == INIT);

  assign g_ok = gbp_valid_i & (gbp_taken_i == update_taken_i);
  assign l_ok = lbp_valid_i & (lbp_taken_i == update_taken_i);

  assign upd_acc = update_valid_i & ~debug_mode_i & run_rd;

  always_comb begin
    s1_d       = '0;
    s1_d.valid = upd_acc;
    s1_d.row   = upd_row;
    s1_d.bank  = upd_bank;
    s1_d.inc   = g_ok & ~l_ok;
    s1_d.dec   = l_ok & ~g_ok;
  end

  // A flush or reset kills the write of the update sitting in stage 1.
  assign s1_we  = rst_ni & s1_q.valid & run_rd;
  assign s1_hit = s1_we & (s1_q.row == upd_row)
                & (s1_q.bank == upd_bank);

  assign s1_rd = upd_rd[s1_q.bank];

  always_comb begin
    s1_cur = fwd_q ? fwd_val_q : s1_rd;
    s1_new = s1_cur;
    unique case (1'b1)
      s1_q.inc: begin
        if (s1_cur != CTR_MAX) s1_new = s1_cur + CTR_BITS'(1);
      end
      s1_q.dec: begin
        if (s1_cur != '0) s1_new = s1_cur - CTR_BITS'(1);
      end
      default: ;
    endcase
  end

  // Stage 0 reads RAM while stage 1 writes it; the hit flag swaps
  // the stale read for the value written on that same edge.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      s1_q      <= '0;
      fwd_q     <= 1'b0;
      fwd_val_q <= '0;
    end else begin
      s1_q      <= s1_d;
      fwd_q     <= upd_acc & s1_hit;
      fwd_val_q <= s1_new;
    end
  end

  for (genvar b = 0; b < IPF; b++) begin : g_ram
    logic [CTR_BITS-1:0] mem [NR_ROWS];
    logic                we;
    logic [ROW_BITS-1:0] waddr;
    logic [CTR_BITS-1:0] wdata;
    logic [CTR_BITS-1:0] rd_q;
    logic                msb_q;

    always_comb begin
      we    = 1'b0;
      waddr = init_row_q;
      wdata = INIT_VAL;
      if (init_we) begin
        we = 1'b1;
      end else if (s1_we && s1_q.bank == BANK_W'(b)) begin
        we    = 1'b1;
        waddr = s1_q.row;
        wdata = s1_new;
      end
    end

    always_ff @(posedge clk_i) begin
      if (we) mem[waddr] <= wdata;
      rd_q <= mem[upd_row];
    end

    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        msb_q <= 1'b0;
      end else begin
        msb_q <= run_rd & mem[pred_row][CTR_BITS-1];
      end
    end

    assign upd_rd[b]   = rd_q;
    assign pred_msb[b] = msb_q;
  end

  assign select_prediction_o = pred_msb;

endmodule

// File: tb/tb_mbp_choice_sync.sv
// Directed + random bench for mbp_choice_sync against a delayed-commit
// counter-table model.
module tb_mbp_choice_sync;

  localparam int NR_ROWS = 512;
  localparam int CMAX    = 3;
  localparam int CINIT   = 1;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        flush_bp_i = 1'b0;
  logic        debug_mode_i = 1'b0;
  logic [31:0] vpc_i = '0;
  logic [7:0]  ghr_i = '0;
  logic        update_valid_i = 1'b0;
  logic [31:0] update_pc_i = '0;
  logic [7:0]  update_ghr_i = '0;
  logic        update_taken_i = 1'b0;
  logic        lbp_valid_i = 1'b0;
  logic        lbp_taken_i = 1'b0;
  logic        gbp_valid_i = 1'b0;
  logic        gbp_taken_i = 1'b0;
  logic [1:0]  select_prediction_o;
  logic        ready_o;

  mbp_choice_sync dut (
    .clk_i               (clk_i),
    .rst_ni              (rst_ni),
    .flush_bp_i          (flush_bp_i),
    .debug_mode_i        (debug_mode_i),
    .vpc_i               (vpc_i),
    .ghr_i               (ghr_i),
    .update_valid_i      (update_valid_i),
    .update_pc_i         (update_pc_i),
    .update_ghr_i        (update_ghr_i),
    .update_taken_i      (update_taken_i),
    .lbp_valid_i         (lbp_valid_i),
    .lbp_taken_i         (lbp_taken_i),
    .gbp_valid_i         (gbp_valid_i),
    .gbp_taken_i         (gbp_taken_i),
    .select_prediction_o (select_prediction_o),
    .ready_o             (ready_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] pc;
    logic [7:0]  gh;
    bit          g_ok;
    bit          l_ok;
    int          at;
  } pend_t;

  int    total = 0;
  int    bad = 0;
  int    cyc = 0;
  int    ctr [2][NR_ROWS];
  bit    run = 0;
  int    left = NR_ROWS;
  pend_t pq [$];

  function automatic int row_of(logic [31:0] pc, logic [7:0] gh);
    int r;
    r = int'((pc >> 2) & 32'h1ff);
`ifdef MBP_CHOICE_GHR_HASH_EN
    r = r ^ int'(gh);
`endif
    return r;
  endfunction

  function automatic int bank_of(logic [31:0] pc);
    return int'((pc >> 1) & 32'h1);
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_fill();
    for (int b = 0; b < 2; b++)
      for (int r = 0; r < NR_ROWS; r++) ctr[b][r] = CINIT;
  endtask

  task automatic commit(pend_t p);
    int b, r;
    b = bank_of(p.pc);
    r = row_of(p.pc, p.gh);
    if (p.g_ok && !p.l_ok && ctr[b][r] < CMAX) ctr[b][r]++;
    if (p.l_ok && !p.g_ok && ctr[b][r] > 0) ctr[b][r]--;
  endtask

  // One clock: predict from the model, advance it, then compare.
  task automatic tick();
    logic [1:0] exp_sel;
    bit         acc;
    pend_t      p;
    while (pq.size() > 0 && pq[0].at + 2 <= cyc) commit(pq.pop_front());
    exp_sel = '0;
    if (rst_ni && run && !flush_bp_i)
      for (int b = 0; b < 2; b++)
        exp_sel[b] = (ctr[b][row_of(vpc_i, ghr_i)] >= 2);
    acc = rst_ni && run && !flush_bp_i && update_valid_i && !debug_mode_i;
    if (!rst_ni || flush_bp_i) begin
      run = 0;
      left = NR_ROWS;
      pq.delete();
      model_fill();
    end else if (!run) begin
      left--;
      if (left == 0) run = 1;
    end
    if (acc) begin
      p.pc   = update_pc_i;
      p.gh   = update_ghr_i;
      p.g_ok = gbp_valid_i && (gbp_taken_i == update_taken_i);
      p.l_ok = lbp_valid_i && (lbp_taken_i == update_taken_i);
      p.at   = cyc;
      pq.push_back(p);
    end
    @(posedge clk_i);
    #1;
    cyc++;
    chk("sel_model", 32'(select_prediction_o), 32'(exp_sel));
    chk("ready_model", 32'(ready_o), 32'(run));
  endtask

  task automatic upd(input logic [31:0] pc, input logic [7:0] gh,
                     input bit inc);
    update_valid_i = 1'b1;
    update_pc_i    = pc;
    update_ghr_i   = gh;
    update_taken_i = 1'b1;
    gbp_valid_i    = 1'b1;
    gbp_taken_i    = inc;
    lbp_valid_i    = 1'b1;
    lbp_taken_i    = !inc;
    tick();
    update_valid_i = 1'b0;
  endtask

  task automatic rd(input logic [31:0] pc, input logic [7:0] gh);
    vpc_i = pc;
    ghr_i = gh;
    tick();
  endtask

  task automatic sweep(string tag);
    for (int i = 0; i < NR_ROWS - 1; i++) tick();
    chk({tag, "_not_ready"}, 32'(ready_o), 0);
    tick();
    chk({tag, "_ready"}, 32'(ready_o), 1);
  endtask

  initial begin
    logic [31:0] pcs [4];
    pcs[0] = 32'h80;
    pcs[1] = 32'h82;
    pcs[2] = 32'h84;
    pcs[3] = 32'h1080;
    model_fill();

    rst_ni = 1'b0;
    repeat (3) tick();
    chk("rst_sel", 32'(select_prediction_o), 0);
    chk("rst_ready", 32'(ready_o), 0);
    rst_ni = 1'b1;
    sweep("init");

    rd(32'h80, 8'h0);
    chk("init_val", 32'(select_prediction_o), 0);

    upd(32'h80, 8'h0, 1'b1);
    tick();
    rd(32'h80, 8'h0);
    chk("inc_once", 32'(select_prediction_o[0]), 1);

    repeat (3) upd(32'h80, 8'h0, 1'b1);
    tick();
    upd(32'h80, 8'h0, 1'b0);
    tick();
    rd(32'h80, 8'h0);
    chk("sat_top", 32'(select_prediction_o[0]), 1);

    repeat (4) upd(32'h80, 8'h0, 1'b0);
    tick();
    rd(32'h80, 8'h0);
    chk("dec_zero", 32'(select_prediction_o[0]), 0);

    repeat (2) upd(32'h80, 8'h0, 1'b1);
    tick();
    rd(32'h80, 8'h0);
    chk("fwd2", 32'(select_prediction_o[0]), 1);

    repeat (2) upd(32'h80, 8'h0, 1'b0);
    repeat (4) upd(32'h80, 8'h0, 1'b1);
    tick();
    upd(32'h80, 8'h0, 1'b0);
    tick();
    rd(32'h80, 8'h0);
    chk("fwd4", 32'(select_prediction_o[0]), 1);

    upd(32'h80, 8'h0, 1'b0);
    rd(32'h80, 8'h0);
    chk("rbw_old", 32'(select_prediction_o[0]), 1);
    rd(32'h80, 8'h0);
    chk("rbw_new", 32'(select_prediction_o[0]), 0);

    debug_mode_i = 1'b1;
    repeat (3) upd(32'h84, 8'h0, 1'b1);
    debug_mode_i = 1'b0;
    tick();
    rd(32'h84, 8'h0);
    chk("debug_drop", 32'(select_prediction_o), 0);

    upd(32'h82, 8'h0, 1'b1);
    tick();
    rd(32'h80, 8'h0);
    chk("bank1", 32'(select_prediction_o), 32'h2);

    upd(32'h86, 8'h0, 1'b1);
    flush_bp_i = 1'b1;
    tick();
    flush_bp_i = 1'b0;
    chk("flush_ready", 32'(ready_o), 0);
    update_valid_i = 1'b1;
    update_pc_i    = 32'h80;
    gbp_valid_i    = 1'b1;
    gbp_taken_i    = 1'b1;
    update_taken_i = 1'b1;
    lbp_valid_i    = 1'b0;
    sweep("flush");
    update_valid_i = 1'b0;
    rd(32'h82, 8'h0);
    chk("flush_reinit", 32'(select_prediction_o), 0);
    rd(32'h80, 8'h0);
    chk("init_drop", 32'(select_prediction_o), 0);

`ifdef MBP_CHOICE_GHR_HASH_EN
    upd(32'h80, 8'h01, 1'b1);
    tick();
    rd(32'h80, 8'h01);
    chk("hash_hit", 32'(select_prediction_o[0]), 1);
    rd(32'h80, 8'h00);
    chk("hash_other", 32'(select_prediction_o[0]), 0);
`endif

    for (int i = 0; i < 800; i++) begin
      update_valid_i = 1'($urandom_range(0, 1));
      update_pc_i    = pcs[$urandom_range(0, 3)];
      update_ghr_i   = 8'($urandom_range(0, 3));
      update_taken_i = 1'($urandom_range(0, 1));
      gbp_valid_i    = 1'($urandom_range(0, 1));
      gbp_taken_i    = 1'($urandom_range(0, 1));
      lbp_valid_i    = 1'($urandom_range(0, 1));
      lbp_taken_i    = 1'($urandom_range(0, 1));
      debug_mode_i   = ($urandom_range(0, 7) == 0);
      vpc_i          = pcs[$urandom_range(0, 3)];
      ghr_i          = 8'($urandom_range(0, 3));
      tick();
    end
    debug_mode_i = 1'b0;

    update_valid_i = 1'b1;
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    update_valid_i = 1'b0;
    chk("rerst_ready", 32'(ready_o), 0);
    chk("rerst_sel", 32'(select_prediction_o), 0);
    sweep("rerst");
    rd(32'h80, 8'h0);
    chk("rerst_val", 32'(select_prediction_o), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
